// File: rtl/ldm_writeback_sequencer_pkg.sv
// Shared definitions for the LDM write-back sequencer: state encoding,
// architectural constants and a register-list population count.
// The WB state only exists when LDM_BASE_WB_EN is defined.
package ldm_writeback_sequencer_pkg;

  localparam int unsigned WordBytesDflt = 4;
  localparam logic [3:0]  RegPc         = 4'd15;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWrite = 3'd2,
    StFin   = 3'd3
`ifdef LDM_BASE_WB_EN
    ,
    StWb    = 3'd4
`endif
  } state_e;

  // Number of registers named by a 16-bit LDM register list.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ldm_writeback_sequencer_lowest_set_bit16.sv
// Combinational 16->4 priority encoder: index of the lowest set bit, plus a
// flag telling whether any bit is set. Index is 0 when the vector is empty.
module ldm_writeback_sequencer_lowest_set_bit16
  import ldm_writeback_sequencer_pkg::*;
(
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  // Scan from R15 down so the lowest set bit is the one left in idx_o.
  always_comb begin
    idx_o   = '0;
    valid_o = |vec_i;
    for (int i = int'(RegPc); i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ldm_writeback_sequencer.sv
// LDM write-back sequencer: walks a register list lowest-first, fetches one
// word per register over a REQ/ACK handshake and writes it to the register
// file. Addresses always ascend; decrement-before just starts 4*N lower.
// Optional feature: define LDM_BASE_WB_EN to add base-register write-back.
module ldm_writeback_sequencer
  import ldm_writeback_sequencer_pkg::*;
#(
  parameter int unsigned WordBytes = WordBytesDflt
) (
  input  logic        clk_i,
  input  logic        reset_i,
`ifdef LDM_BASE_WB_EN
  input  logic        wb_i,
  input  logic [3:0]  base_reg_i,
`endif
  input  logic        start_i,
  input  logic [15:0] reglist_i,
  input  logic [31:0] base_addr_i,
  input  logic        up_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [3:0]  rf_c_o,
  output logic [31:0] rf_pc_o,
  output logic        rf_enable_o,
  output logic        busy_o,
  output logic        done_o
);

  state_e      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [31:0] cur_q, cur_d;
  logic [3:0]  rf_c_q, rf_c_d;
  logic [31:0] rf_pc_q, rf_pc_d;
`ifdef LDM_BASE_WB_EN
  logic        wb_go_q, wb_go_d;
  logic [3:0]  base_reg_q, base_reg_d;
  logic [31:0] wb_val_q, wb_val_d;
`endif

  logic [3:0]  lsb_idx;
  logic        lsb_valid;
  logic [4:0]  reg_cnt;
  logic [31:0] step;
  logic [31:0] span;

  assign reg_cnt = popcount16(reglist_i);
  assign step    = 32'(WordBytes);
  assign span    = 32'(reg_cnt) * step;

  // The pending bit is cleared as soon as its word is accepted, so in WRITE
  // the encoder's valid flag directly answers "more registers to load?".
  ldm_writeback_sequencer_lowest_set_bit16 u_lsb (
    .vec_i   (pend_q),
    .idx_o   (lsb_idx),
    .valid_o (lsb_valid)
  );

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    rf_c_d  = rf_c_q;
    rf_pc_d = rf_pc_q;
`ifdef LDM_BASE_WB_EN
    wb_go_d    = wb_go_q;
    base_reg_d = base_reg_q;
    wb_val_d   = wb_val_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pend_d  = reglist_i;
          cur_d   = up_i ? base_addr_i : base_addr_i - span;
`ifdef LDM_BASE_WB_EN
          // A loaded base register wins over the written-back address.
          wb_go_d    = wb_i && !reglist_i[base_reg_i];
          base_reg_d = base_reg_i;
          wb_val_d   = up_i ? base_addr_i + span : base_addr_i - span;
`endif
          state_d = (reg_cnt != 5'd0) ? StReq : StFin;
        end
      end
      StReq: begin
        if (mem_ack_i) begin
          rf_pc_d = mem_data_i;
          rf_c_d  = lsb_idx;
          pend_d  = pend_q & ~(16'd1 << lsb_idx);
          state_d = StWrite;
        end
      end
      StWrite: begin
        cur_d = cur_q + step;
        if (lsb_valid) begin
          state_d = StReq;
        end else begin
`ifdef LDM_BASE_WB_EN
          if (wb_go_q) begin
            rf_c_d  = base_reg_q;
            rf_pc_d = wb_val_q;
            state_d = StWb;
          end else begin
            state_d = StFin;
          end
`else
          state_d = StFin;
`endif
        end
      end
`ifdef LDM_BASE_WB_EN
      StWb: begin
        state_d = StFin;
      end
`endif
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any in-flight transfer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      pend_q  <= '0;
      cur_q   <= '0;
      rf_c_q  <= '0;
      rf_pc_q <= '0;
`ifdef LDM_BASE_WB_EN
      wb_go_q    <= 1'b0;
      base_reg_q <= '0;
      wb_val_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      rf_c_q  <= rf_c_d;
      rf_pc_q <= rf_pc_d;
`ifdef LDM_BASE_WB_EN
      wb_go_q    <= wb_go_d;
      base_reg_q <= base_reg_d;
      wb_val_q   <= wb_val_d;
`endif
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    mem_req_o   = (state_q == StReq);
    rf_enable_o = (state_q == StWrite);
    busy_o      = (state_q == StReq) || (state_q == StWrite);
`ifdef LDM_BASE_WB_EN
    rf_enable_o = rf_enable_o || (state_q == StWb);
    busy_o      = busy_o || (state_q == StWb);
`endif
    done_o      = (state_q == StFin);
  end

  assign mem_addr_o = cur_q;
  assign rf_c_o     = rf_c_q;
  assign rf_pc_o    = rf_pc_q;

endmodule

// File: tb/tb_ldm_writeback_sequencer.sv
// Self-checking bench for ldm_writeback_sequencer. Expected memory addresses
// and register-file writes are queued when an LDM is launched and popped as
// the DUT requests memory and writes the register file.
module tb_ldm_writeback_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] reglist;
  logic [31:0] base_addr;
  logic        up;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [3:0]  rf_c;
  logic [31:0] rf_pc;
  logic        rf_enable;
  logic        busy;
  logic        done;
`ifdef LDM_BASE_WB_EN
  logic        wb;
  logic [3:0]  base_reg;
`endif

  int total = 0;
  int bad   = 0;
  int ack_delay = 0;
  int done_cnt  = 0;
  logic [31:0] exp_addr_q[$];
  logic [35:0] exp_wr_q[$];

  always #5 clk = ~clk;

  ldm_writeback_sequencer dut (
    .clk_i       (clk),
    .reset_i     (reset),
`ifdef LDM_BASE_WB_EN
    .wb_i        (wb),
    .base_reg_i  (base_reg),
`endif
    .start_i     (start),
    .reglist_i   (reglist),
    .base_addr_i (base_addr),
    .up_i        (up),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_ack_i   (mem_ack),
    .mem_data_i  (mem_data),
    .rf_c_o      (rf_c),
    .rf_pc_o     (rf_pc),
    .rf_enable_o (rf_enable),
    .busy_o      (busy),
    .done_o      (done)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory model: acks after ack_delay waiting cycles, checks address order
  // and that the request holds steady while waiting.
  initial begin
    int          wait_cnt;
    logic [31:0] first_addr;
    logic [31:0] ea;
    wait_cnt   = 0;
    first_addr = '0;
    mem_ack    = 1'b0;
    mem_data   = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt == 0) first_addr = mem_addr;
        else check_eq("addr_stable", 36'(mem_addr), 36'(first_addr));
        if (wait_cnt >= ack_delay) begin
          if (exp_addr_q.size() == 0) begin
            check_eq("spurious_req", 36'(mem_req), 36'd0);
          end else begin
            ea = exp_addr_q.pop_front();
            check_eq("mem_addr", 36'(mem_addr), 36'(ea));
          end
          mem_data = mem_word(mem_addr);
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Register-file monitor: every write must match the head of the scoreboard.
  initial begin
    logic [35:0] ew;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rf_enable) begin
        if (exp_wr_q.size() == 0) begin
          check_eq("spurious_write", 36'(rf_enable), 36'd0);
        end else begin
          ew = exp_wr_q.pop_front();
          check_eq("rf_write", {rf_c, rf_pc}, ew);
        end
      end
    end
  end

  task automatic run_ldm(input logic [15:0] rl, input logic [31:0] base, input logic up_v,
                         input int dly, input logic wb_v, input logic [3:0] breg,
                         input bit poke);
    int          n;
    int          wb_hit;
    int          exp_cyc;
    int          got_cyc;
    logic [31:0] a;
    n = $countones(rl);
    wb_hit  = 0;
    got_cyc = -1;
    a = up_v ? base : base - 32'(4 * n);
    for (int i = 0; i < 16; i++) begin
      if (rl[i]) begin
        exp_addr_q.push_back(a);
        exp_wr_q.push_back({4'(i), mem_word(a)});
        a = a + 32'd4;
      end
    end
`ifdef LDM_BASE_WB_EN
    if (wb_v && !rl[breg] && n != 0) begin
      wb_hit = 1;
      exp_wr_q.push_back({breg, up_v ? base + 32'(4 * n) : base - 32'(4 * n)});
    end
`endif
    exp_cyc   = n * (dly + 2) + 1 + wb_hit;
    ack_delay = dly;
    @(posedge clk);
    #1;
    start     = 1'b1;
    reglist   = rl;
    base_addr = base;
    up        = up_v;
`ifdef LDM_BASE_WB_EN
    wb        = wb_v;
    base_reg  = breg;
`endif
    @(posedge clk);
    #1;
    start   = 1'b0;
    reglist = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) check_eq("busy_on", 36'(busy), 36'(n != 0));
      if (poke && c == 3) begin
        start   = 1'b1;
        reglist = 16'hFFFF;
      end
      if (poke && c == 4) start = 1'b0;
      if (done) begin
        got_cyc = c;
        break;
      end
    end
    start = 1'b0;
    check_eq("done_cycle", 36'(got_cyc), 36'(exp_cyc));
    check_eq("busy_at_done", 36'(busy), 36'd0);
    @(negedge clk);
    check_eq("done_one_cycle", 36'(done), 36'd0);
    check_eq("writes_drained", 36'(exp_wr_q.size()), 36'd0);
    check_eq("addrs_drained", 36'(exp_addr_q.size()), 36'd0);
  endtask

  initial begin
    int d0;
    reset     = 1'b1;
    start     = 1'b0;
    reglist   = '0;
    base_addr = '0;
    up        = 1'b0;
`ifdef LDM_BASE_WB_EN
    wb        = 1'b0;
    base_reg  = '0;
`endif
    @(negedge clk);
    check_eq("rst_outputs", {mem_req, rf_enable, busy, done, rf_c, 28'd0},
             {4'd0, 4'd0, 28'd0});
    check_eq("rst_addr_pc", 36'(mem_addr | rf_pc), 36'd0);
    @(negedge clk);
    reset = 1'b0;

    run_ldm(16'h0011, 32'h0000_1000, 1'b1, 0, 1'b0, 4'd0, 1'b0);
    run_ldm(16'h8003, 32'h0000_2000, 1'b0, 0, 1'b0, 4'd0, 1'b0);
    run_ldm(16'h0000, 32'h0000_4000, 1'b1, 0, 1'b0, 4'd0, 1'b0);
    run_ldm(16'h0421, 32'h0000_5000, 1'b1, 3, 1'b0, 4'd0, 1'b1);
    run_ldm(16'hFFFF, 32'h0000_0010, 1'b0, 1, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      run_ldm(16'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 2)), 1'b0, 4'd0,
              1'b0);
    end
`ifdef LDM_BASE_WB_EN
    run_ldm(16'h0006, 32'hFFFF_FFFC, 1'b1, 0, 1'b1, 4'd0, 1'b0);
    run_ldm(16'h0006, 32'h0000_3000, 1'b0, 1, 1'b1, 4'd9, 1'b0);
    run_ldm(16'h0006, 32'h0000_3000, 1'b1, 0, 1'b1, 4'd2, 1'b0);
`endif

    // Reset in the middle of a waiting request: nothing may complete.
    ack_delay = 20;
    @(posedge clk);
    #1;
    start     = 1'b1;
    reglist   = 16'h00F0;
    base_addr = 32'h0000_3000;
    up        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("req_before_reset", 36'(mem_req), 36'd1);
    reset = 1'b1;
    d0    = done_cnt;
    @(negedge clk);
    check_eq("abort_ctrl", {mem_req, rf_enable, busy, done}, 36'd0);
    check_eq("abort_data", {rf_c, 32'(mem_addr | rf_pc)}, 36'd0);
    reset     = 1'b0;
    ack_delay = 0;
    repeat (20) @(negedge clk);
    check_eq("abort_no_done", 36'(done_cnt), 36'(d0));
    check_eq("abort_idle", {mem_req, busy}, 36'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
